// File: rtl/axis_deadlock_watchdog.sv
// -----------------------------------------------------------------------------
// axis_deadlock_watchdog
//
// Watches a set of AXI-Stream channels for a stall that persists too long.
// A channel is "qualified blocked" when it reports a stall, its owning instance
// is not idle and its monitor is enabled. Once any qualified block persists for
// THRESHOLD consecutive cycles the watchdog raises block and snapshots which
// channels were blocked at that moment.
//
// Ports
//   clock            sole clock, rising edge
//   reset            synchronous, active-high reset
//   axis_block_sigs  [NUM_CH]  per-channel stall indication
//   inst_idle_sigs   [NUM_CH]  per-channel instance idle (masks the stall)
//   ch_enable        [NUM_CH]  per-channel monitor enable
//   clear            drop a latched deadlock and restart watching
//   block            registered deadlock flag
//   block_ch         [NUM_CH]  qualified-block channels captured at detection
//   block_idx        lowest index set in block_ch
//   stall_cnt        [CNT_W]   consecutive qualified-block cycles (saturating)
// -----------------------------------------------------------------------------
module axis_deadlock_watchdog #(
    parameter int NUM_CH    = 3,
    parameter int CNT_W     = 16,
    parameter int THRESHOLD = 1024,
    parameter int STICKY    = 1
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic [NUM_CH-1:0]                            axis_block_sigs,
    input  logic [NUM_CH-1:0]                            inst_idle_sigs,
    input  logic [NUM_CH-1:0]                            ch_enable,
    input  logic                                         clear,
    output logic                                         block,
    output logic [NUM_CH-1:0]                            block_ch,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] block_idx,
    output logic [CNT_W-1:0]                             stall_cnt
);

    localparam int              IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESHOLD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic             STICKY_EN = (STICKY != 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WATCH   = 2'd1,
        ST_BLOCKED = 2'd2
    } state_t;

    // Lowest set bit of a channel vector; zero when the vector is empty.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_CH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        // Scan from the top so the lowest set bit is the last one written.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_t             state_r, state_nxt_s;
    logic               block_r, block_nxt_s;
    logic [NUM_CH-1:0]  block_ch_r, block_ch_nxt_s;
    logic [IDX_W-1:0]   block_idx_r, block_idx_nxt_s;
    logic [CNT_W-1:0]   stall_cnt_r, stall_cnt_nxt_s;

    logic [NUM_CH-1:0]  q_s;
    logic               any_q_s;
    logic [CNT_W-1:0]   cnt_inc_s;

    assign q_s       = axis_block_sigs & ~inst_idle_sigs & ch_enable;
    assign any_q_s   = |q_s;
    // Saturating increment: the counter pins at all-ones rather than wrapping.
    assign cnt_inc_s = (stall_cnt_r == CNT_MAX) ? stall_cnt_r : (stall_cnt_r + CNT_ONE);

    // Next-state and next-output logic for the watchdog FSM.
    always_comb begin
        state_nxt_s     = state_r;
        block_nxt_s     = block_r;
        block_ch_nxt_s  = block_ch_r;
        block_idx_nxt_s = block_idx_r;
        stall_cnt_nxt_s = stall_cnt_r;

        if (clear) begin
            // Clear wins over anything the channels report this cycle.
            state_nxt_s     = ST_IDLE;
            block_nxt_s     = 1'b0;
            block_ch_nxt_s  = {NUM_CH{1'b0}};
            block_idx_nxt_s = {IDX_W{1'b0}};
            stall_cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    block_nxt_s     = 1'b0;
                    block_ch_nxt_s  = {NUM_CH{1'b0}};
                    block_idx_nxt_s = {IDX_W{1'b0}};
                    if (any_q_s) begin
                        stall_cnt_nxt_s = CNT_ONE;
                        // A threshold of one trips on the very first sample.
                        if (THRESH_C == CNT_ONE) begin
                            state_nxt_s     = ST_BLOCKED;
                            block_nxt_s     = 1'b1;
                            block_ch_nxt_s  = q_s;
                            block_idx_nxt_s = lowest_set(q_s);
                        end else begin
                            state_nxt_s     = ST_WATCH;
                        end
                    end else begin
                        stall_cnt_nxt_s = {CNT_W{1'b0}};
                    end
                end
                ST_WATCH: begin
                    if (!any_q_s) begin
                        state_nxt_s     = ST_IDLE;
                        stall_cnt_nxt_s = {CNT_W{1'b0}};
                    end else begin
                        stall_cnt_nxt_s = cnt_inc_s;
                        if (cnt_inc_s == THRESH_C) begin
                            state_nxt_s     = ST_BLOCKED;
                            block_nxt_s     = 1'b1;
                            block_ch_nxt_s  = q_s;
                            block_idx_nxt_s = lowest_set(q_s);
                        end else begin
                            state_nxt_s     = ST_WATCH;
                        end
                    end
                end
                ST_BLOCKED: begin
                    if (!any_q_s && !STICKY_EN) begin
                        // Auto-release: the stall cleared, so forget the event.
                        state_nxt_s     = ST_IDLE;
                        block_nxt_s     = 1'b0;
                        block_ch_nxt_s  = {NUM_CH{1'b0}};
                        block_idx_nxt_s = {IDX_W{1'b0}};
                        stall_cnt_nxt_s = {CNT_W{1'b0}};
                    end else if (any_q_s) begin
                        stall_cnt_nxt_s = cnt_inc_s;
                    end else begin
                        stall_cnt_nxt_s = stall_cnt_r;
                    end
                end
                default: begin
                    state_nxt_s     = ST_IDLE;
                    block_nxt_s     = 1'b0;
                    block_ch_nxt_s  = {NUM_CH{1'b0}};
                    block_idx_nxt_s = {IDX_W{1'b0}};
                    stall_cnt_nxt_s = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            block_r     <= 1'b0;
            block_ch_r  <= {NUM_CH{1'b0}};
            block_idx_r <= {IDX_W{1'b0}};
            stall_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            block_r     <= block_nxt_s;
            block_ch_r  <= block_ch_nxt_s;
            block_idx_r <= block_idx_nxt_s;
            stall_cnt_r <= stall_cnt_nxt_s;
        end
    end

    assign block     = block_r;
    assign block_ch  = block_ch_r;
    assign block_idx = block_idx_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_axis_deadlock_watchdog.sv
// -----------------------------------------------------------------------------
// tb_axis_deadlock_watchdog
//
// Three watchdog instances with different parameter sets:
//   0: THRESHOLD=4, CNT_W=16, STICKY=1
//   1: THRESHOLD=7, CNT_W=3,  STICKY=0  (saturation + auto-release)
//   2: THRESHOLD=1, CNT_W=2,  STICKY=1  (immediate trip, small counter)
// A table of hand-computed vectors is applied one clock at a time; each
// vector's expected outputs go into a scoreboard queue when driven and are
// popped and compared just after the rising edge.
// -----------------------------------------------------------------------------
module tb_axis_deadlock_watchdog;

    logic clock;
    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst_s  [0:2];
    logic       clr_s  [0:2];
    logic [2:0] blk_s  [0:2];
    logic [2:0] idl_s  [0:2];
    logic [2:0] en_s   [0:2];

    logic       block_a, block_b, block_c;
    logic [2:0] ch_a, ch_b, ch_c;
    logic [1:0] idx_a, idx_b, idx_c;
    logic [15:0] cnt_a;
    logic [2:0]  cnt_b;
    logic [1:0]  cnt_c;

    axis_deadlock_watchdog #(.NUM_CH(3), .CNT_W(16), .THRESHOLD(4), .STICKY(1)) dut_a (
        .clock(clock), .reset(rst_s[0]), .axis_block_sigs(blk_s[0]),
        .inst_idle_sigs(idl_s[0]), .ch_enable(en_s[0]), .clear(clr_s[0]),
        .block(block_a), .block_ch(ch_a), .block_idx(idx_a), .stall_cnt(cnt_a));

    axis_deadlock_watchdog #(.NUM_CH(3), .CNT_W(3), .THRESHOLD(7), .STICKY(0)) dut_b (
        .clock(clock), .reset(rst_s[1]), .axis_block_sigs(blk_s[1]),
        .inst_idle_sigs(idl_s[1]), .ch_enable(en_s[1]), .clear(clr_s[1]),
        .block(block_b), .block_ch(ch_b), .block_idx(idx_b), .stall_cnt(cnt_b));

    axis_deadlock_watchdog #(.NUM_CH(3), .CNT_W(2), .THRESHOLD(1), .STICKY(1)) dut_c (
        .clock(clock), .reset(rst_s[2]), .axis_block_sigs(blk_s[2]),
        .inst_idle_sigs(idl_s[2]), .ch_enable(en_s[2]), .clear(clr_s[2]),
        .block(block_c), .block_ch(ch_c), .block_idx(idx_c), .stall_cnt(cnt_c));

    typedef struct {
        int          dut;
        logic        rst;
        logic        clr;
        logic [2:0]  blk;
        logic [2:0]  idl;
        logic [2:0]  en;
        logic        e_block;
        logic [2:0]  e_ch;
        logic [1:0]  e_idx;
        logic [15:0] e_cnt;
        string       tag;
    } vec_t;

    typedef struct {
        int          dut;
        logic        e_block;
        logic [2:0]  e_ch;
        logic [1:0]  e_idx;
        logic [15:0] e_cnt;
        string       tag;
        int          num;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   tests_run;
    int   tests_failed;

    function automatic void add(input int d, input logic r, input logic c,
                                input logic [2:0] b, input logic [2:0] i,
                                input logic [2:0] e, input logic eb,
                                input logic [2:0] ech, input logic [1:0] eidx,
                                input logic [15:0] ecnt, input string t);
        vec_t v;
        v.dut = d; v.rst = r; v.clr = c; v.blk = b; v.idl = i; v.en = e;
        v.e_block = eb; v.e_ch = ech; v.e_idx = eidx; v.e_cnt = ecnt; v.tag = t;
        vecs.push_back(v);
    endfunction

    task automatic apply(input vec_t v, input int n);
        exp_t        x;
        logic        a_block;
        logic [2:0]  a_ch;
        logic [1:0]  a_idx;
        logic [15:0] a_cnt;
        @(negedge clock);
        rst_s[v.dut] = v.rst;
        clr_s[v.dut] = v.clr;
        blk_s[v.dut] = v.blk;
        idl_s[v.dut] = v.idl;
        en_s[v.dut]  = v.en;
        x.dut = v.dut; x.e_block = v.e_block; x.e_ch = v.e_ch;
        x.e_idx = v.e_idx; x.e_cnt = v.e_cnt; x.tag = v.tag; x.num = n;
        sb.push_back(x);
        @(posedge clock);
        #1;
        x = sb.pop_front();
        case (x.dut)
            0: begin a_block = block_a; a_ch = ch_a; a_idx = idx_a; a_cnt = cnt_a; end
            1: begin a_block = block_b; a_ch = ch_b; a_idx = idx_b; a_cnt = {13'd0, cnt_b}; end
            default: begin a_block = block_c; a_ch = ch_c; a_idx = idx_c; a_cnt = {14'd0, cnt_c}; end
        endcase
        tests_run++;
        if (a_block !== x.e_block || a_ch !== x.e_ch || a_idx !== x.e_idx || a_cnt !== x.e_cnt) begin
            tests_failed++;
            $display("FAIL %s vec %0d dut %0d: got block=%0b ch=%b idx=%0d cnt=%0d, want block=%0b ch=%b idx=%0d cnt=%0d",
                     x.tag, x.num, x.dut, a_block, a_ch, a_idx, a_cnt,
                     x.e_block, x.e_ch, x.e_idx, x.e_cnt);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int d = 0; d < 3; d++) begin
            rst_s[d] = 1'b1; clr_s[d] = 1'b0;
            blk_s[d] = 3'b000; idl_s[d] = 3'b000; en_s[d] = 3'b000;
        end
        repeat (2) @(posedge clock);

        // ---------------- dut 0: THRESHOLD=4, sticky ----------------
        add(0, 1'b1, 1'b0, 3'b000, 3'b000, 3'b111, 1'b0, 3'b000, 2'd0, 16'd0, "reset_a");
        add(0, 1'b0, 1'b0, 3'b010, 3'b000, 3'b111, 1'b0, 3'b000, 2'd0, 16'd1, "det_c1");
        add(0, 1'b0, 1'b0, 3'b010, 3'b000, 3'b111, 1'b0, 3'b000, 2'd0, 16'd2, "det_c2");
        add(0, 1'b0, 1'b0, 3'b010, 3'b000, 3'b111, 1'b0, 3'b000, 2'd0, 16'd3, "det_c3");
        add(0, 1'b0, 1'b0, 3'b010, 3'b000, 3'b111, 1'b1, 3'b010, 2'd1, 16'd4, "det_trip");
        for (int k = 0; k < 10; k++)
            add(0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b111, 1'b1, 3'b010, 2'd1, 16'd4, "sticky_hold");
        add(0, 1'b0, 1'b0, 3'b101, 3'b000, 3'b111, 1'b1, 3'b010, 2'd1, 16'd5, "blocked_inc");
        add(0, 1'b0, 1'b0, 3'b101, 3'b000, 3'b111, 1'b1, 3'b010, 2'd1, 16'd6, "blocked_inc");
        add(0, 1'b0, 1'b1, 3'b001, 3'b000, 3'b111, 1'b0, 3'b000, 2'd0, 16'd0, "clear");
        add(0, 1'b0, 1'b0, 3'b001, 3'b000, 3'b111, 1'b0, 3'b000, 2'd0, 16'd1, "post_clear");
        add(0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b111, 1'b0, 3'b000, 2'd0, 16'd0, "gap_idle");
        // broken run: 1,2,3,0,1,2,3 never trips
        for (int k = 1; k <= 3; k++)
            add(0, 1'b0, 1'b0, 3'b001, 3'b000, 3'b111, 1'b0, 3'b000, 2'd0, 16'(k), "gap_run1");
        add(0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b111, 1'b0, 3'b000, 2'd0, 16'd0, "gap");
        for (int k = 1; k <= 3; k++)
            add(0, 1'b0, 1'b0, 3'b001, 3'b000, 3'b111, 1'b0, 3'b000, 2'd0, 16'(k), "gap_run2");
        add(0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b111, 1'b0, 3'b000, 2'd0, 16'd0, "gap_end");
        // enable / idle masking
        add(0, 1'b0, 1'b0, 3'b011, 3'b000, 3'b111, 1'b0, 3'b000, 2'd0, 16'd1, "mask_c1");
        add(0, 1'b0, 1'b0, 3'b011, 3'b000, 3'b101, 1'b0, 3'b000, 2'd0, 16'd2, "mask_en_part");
        add(0, 1'b0, 1'b0, 3'b010, 3'b000, 3'b101, 1'b0, 3'b000, 2'd0, 16'd0, "mask_en_drop");
        add(0, 1'b0, 1'b0, 3'b010, 3'b010, 3'b111, 1'b0, 3'b000, 2'd0, 16'd0, "mask_idle");
        add(0, 1'b0, 1'b0, 3'b110, 3'b010, 3'b111, 1'b0, 3'b000, 2'd0, 16'd1, "idx2_c1");
        add(0, 1'b0, 1'b0, 3'b110, 3'b010, 3'b111, 1'b0, 3'b000, 2'd0, 16'd2, "idx2_c2");
        add(0, 1'b0, 1'b0, 3'b110, 3'b010, 3'b111, 1'b0, 3'b000, 2'd0, 16'd3, "idx2_c3");
        add(0, 1'b0, 1'b0, 3'b110, 3'b010, 3'b111, 1'b1, 3'b100, 2'd2, 16'd4, "idx2_trip");
        // reset mid-BLOCKED and mid-WATCH, counting restarts from 1
        add(0, 1'b1, 1'b0, 3'b110, 3'b000, 3'b111, 1'b0, 3'b000, 2'd0, 16'd0, "rst_blocked");
        add(0, 1'b0, 1'b0, 3'b110, 3'b000, 3'b111, 1'b0, 3'b000, 2'd0, 16'd1, "rst_restart");
        add(0, 1'b0, 1'b0, 3'b110, 3'b000, 3'b111, 1'b0, 3'b000, 2'd0, 16'd2, "rst_c2");
        add(0, 1'b1, 1'b0, 3'b110, 3'b000, 3'b111, 1'b0, 3'b000, 2'd0, 16'd0, "rst_watch");
        for (int k = 1; k <= 3; k++)
            add(0, 1'b0, 1'b0, 3'b110, 3'b000, 3'b111, 1'b0, 3'b000, 2'd0, 16'(k), "lowbit_run");
        add(0, 1'b0, 1'b0, 3'b110, 3'b000, 3'b111, 1'b1, 3'b110, 2'd1, 16'd4, "lowbit_trip");
        add(0, 1'b0, 1'b1, 3'b000, 3'b000, 3'b111, 1'b0, 3'b000, 2'd0, 16'd0, "clear2");
        // all channels blocked but every instance idle: never counts
        for (int k = 0; k < 2000; k++)
            add(0, 1'b0, 1'b0, 3'b111, 3'b111, 3'b111, 1'b0, 3'b000, 2'd0, 16'd0, "all_idle");

        // ---------------- dut 1: THRESHOLD=7, CNT_W=3, auto-release ----------------
        add(1, 1'b1, 1'b0, 3'b000, 3'b000, 3'b111, 1'b0, 3'b000, 2'd0, 16'd0, "reset_b");
        for (int k = 1; k <= 6; k++)
            add(1, 1'b0, 1'b0, 3'b100, 3'b000, 3'b111, 1'b0, 3'b000, 2'd0, 16'(k), "sat_run");
        add(1, 1'b0, 1'b0, 3'b100, 3'b000, 3'b111, 1'b1, 3'b100, 2'd2, 16'd7, "sat_trip");
        add(1, 1'b0, 1'b0, 3'b100, 3'b000, 3'b111, 1'b1, 3'b100, 2'd2, 16'd7, "sat_hold");
        add(1, 1'b0, 1'b0, 3'b100, 3'b000, 3'b111, 1'b1, 3'b100, 2'd2, 16'd7, "sat_hold");
        add(1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b111, 1'b0, 3'b000, 2'd0, 16'd0, "auto_release");
        add(1, 1'b0, 1'b0, 3'b100, 3'b000, 3'b111, 1'b0, 3'b000, 2'd0, 16'd1, "release_restart");
        add(1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b111, 1'b0, 3'b000, 2'd0, 16'd0, "release_idle");

        // ---------------- dut 2: THRESHOLD=1, CNT_W=2, sticky ----------------
        add(2, 1'b1, 1'b0, 3'b000, 3'b000, 3'b111, 1'b0, 3'b000, 2'd0, 16'd0, "reset_c");
        add(2, 1'b0, 1'b0, 3'b001, 3'b000, 3'b111, 1'b1, 3'b001, 2'd0, 16'd1, "thr1_trip");
        add(2, 1'b0, 1'b0, 3'b011, 3'b000, 3'b111, 1'b1, 3'b001, 2'd0, 16'd2, "thr1_inc");
        add(2, 1'b0, 1'b0, 3'b011, 3'b000, 3'b111, 1'b1, 3'b001, 2'd0, 16'd3, "thr1_max");
        add(2, 1'b0, 1'b0, 3'b011, 3'b000, 3'b111, 1'b1, 3'b001, 2'd0, 16'd3, "thr1_sat");
        add(2, 1'b0, 1'b0, 3'b000, 3'b000, 3'b111, 1'b1, 3'b001, 2'd0, 16'd3, "thr1_sticky");
        add(2, 1'b0, 1'b1, 3'b000, 3'b000, 3'b111, 1'b0, 3'b000, 2'd0, 16'd0, "thr1_clear");
        add(2, 1'b0, 1'b0, 3'b010, 3'b000, 3'b010, 1'b1, 3'b010, 2'd1, 16'd1, "thr1_ch1");
        add(2, 1'b0, 1'b0, 3'b010, 3'b000, 3'b000, 1'b1, 3'b010, 2'd1, 16'd1, "thr1_disabled_hold");
        add(2, 1'b1, 1'b0, 3'b010, 3'b000, 3'b010, 1'b0, 3'b000, 2'd0, 16'd0, "thr1_reset");

        for (int n = 0; n < vecs.size(); n++) begin
            apply(vecs[n], n);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
